// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM state encoding and baud divider helper
//               for the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;
   localparam int unsigned DEFAULT_BAUD     = 9600;
   localparam int unsigned OVERSAMPLE       = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_e;

   // Clocks per oversample tick (integer division, 651 at the defaults)
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Free-running divider producing one oversample tick every DIV
//               clocks; clear holds the counter at zero so the first tick
//               after release lands exactly DIV clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
   parameter int unsigned DIV = 651
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned  CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap at LAST, or restart when cleared
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !clear && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with 16x oversampling, frame error pulse
//               and a first-word fall-through receive FIFO with sticky
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter int unsigned BAUD       = DEFAULT_BAUD,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          RsRx,
   input  logic                          rd_en,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   output logic [7:0]                    last_byte,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);

   // ---------------- synchronizer + receive FSM state ----------------
   logic       sync1_q, sync2_q;
   logic       rx_sync;
   logic       tick;
   logic       push;
   rx_state_e  state_q, state_d;
   logic [3:0] os_cnt_q, os_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       frame_err_q, frame_err_d;

   // ---------------- FIFO state ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    last_byte_q, last_byte_d;
   logic          fifo_full, fifo_empty, do_pop, do_write;

   // Two-flop synchronizer on the asynchronous line; idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= RsRx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_sync = sync2_q;

   // Divider is held at zero while idle so ticks align to the start edge
   baud_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == ST_IDLE),
      .tick  (tick)
   );

   // Receive FSM: next state, sample counters, shift register, push strobe
   always_comb begin
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            os_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
            if (!rx_sync) state_d = ST_START;
         end
         ST_START: begin
            if (tick) begin
               if (os_cnt_q == 4'd7) begin
                  os_cnt_d = 4'd0;
                  state_d  = rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (os_cnt_q == 4'd15) begin
                  os_cnt_d  = 4'd0;
                  shift_d   = {rx_sync, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_d = ST_STOP;
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (os_cnt_q == 4'd15) begin
                  os_cnt_d = 4'd0;
                  if (rx_sync) begin
                     push    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_WAIT_HIGH;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 4'd1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_sync) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO bookkeeping: a pop on a full FIFO frees the slot for a same-cycle push
   always_comb begin
      fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
      fifo_empty  = (count_q == '0);
      do_pop      = rd_en && !fifo_empty;
      do_write    = push && (!fifo_full || do_pop);
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (push && !do_write);
      last_byte_d = last_byte_q;
      if (do_write) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         last_byte_d     = shift_q;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_write, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers for FSM and FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         os_cnt_q    <= 4'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         frame_err_q <= 1'b0;
         mem_q       <= '{default: 8'd0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         last_byte_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         last_byte_q <= last_byte_d;
      end
   end

   assign rx_valid   = !fifo_empty;
   assign rx_data    = fifo_empty ? 8'd0 : mem_q[rd_ptr_q];
   assign last_byte  = last_byte_q;
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver with a byte
//               scoreboard queue modelling the receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int unsigned CLK_FREQ = 3_200_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int unsigned DEPTH    = 4;
   localparam int DIV       = CLK_FREQ / (BAUD * 16);
   localparam int BIT       = 16 * DIV;
   // Edges from the start-bit drive edge to the stop-bit sampling edge:
   // 3 for synchronizer + IDLE->START, then 8+8*16+16 ticks of DIV clocks
   localparam int STOP_EDGE = 3 + 152 * DIV;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       RsRx  = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] last_byte;
   logic       frame_err;
   logic       overflow;
   logic [2:0] fifo_count;

   int vectors     = 0;
   int miscompares = 0;
   int fe_cnt      = 0;
   int fe0;

   logic [7:0] exp_q [$];
   logic [7:0] m_last;
   logic       m_ovf;

   uart_receiver #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .RsRx       (RsRx),
      .rd_en      (rd_en),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .last_byte  (last_byte),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // Count cycles with frame_err high
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_good(input logic [7:0] b);
      if (exp_q.size() < DEPTH) begin
         exp_q.push_back(b);
         m_last = b;
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_last = 8'd0;
      m_ovf  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // 8N1 frame, LSB first, followed by one idle bit period
   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(posedge clk); #1 RsRx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 RsRx = b[i];
         repeat (BIT) @(posedge clk);
      end
      #1 RsRx = stop;
      repeat (BIT) @(posedge clk);
      #1 RsRx = 1'b1;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      chk({tag, ".count"},    32'(fifo_count), exp_q.size());
      chk({tag, ".valid"},    32'(rx_valid),   32'(exp_q.size() != 0));
      chk({tag, ".last"},     32'(last_byte),  32'(m_last));
      chk({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
   endtask

   task automatic pop_check(input string tag);
      chk({tag, ".valid"}, 32'(rx_valid), 32'd1);
      chk({tag, ".data"},  32'(rx_data),  32'(exp_q[0]));
      rd_en = 1'b1;
      @(posedge clk); #1 rd_en = 1'b0;
      void'(exp_q.pop_front());
   endtask

   initial begin
      // ---- reset values ----
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      chk("rst.valid", 32'(rx_valid), 0);
      chk("rst.data",  32'(rx_data), 0);
      chk("rst.last",  32'(last_byte), 0);
      chk("rst.count", 32'(fifo_count), 0);
      chk("rst.ovf",   32'(overflow), 0);
      chk("rst.ferr",  32'(frame_err), 0);

      // ---- 0xA5, including one-clock push latency ----
      fe0 = fe_cnt;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(posedge clk);
            repeat (STOP_EDGE - 1) @(posedge clk);
            #1 chk("a5.lat_before", 32'(rx_valid), 0);
            @(posedge clk);
            #1 chk("a5.lat_after", 32'(rx_valid), 1);
         end
      join
      model_good(8'hA5);
      check_status("a5");
      chk("a5.ferr_never", fe_cnt - fe0, 0);
      pop_check("a5.pop");
      check_status("a5.empty");

      // ---- short low glitch is rejected ----
      @(posedge clk); #1 RsRx = 1'b0;
      repeat (3 * BIT / 16) @(posedge clk);
      #1 RsRx = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      #1;
      chk("glitch.state", 32'(dut.state_q), 32'(ST_IDLE));
      check_status("glitch");

      // ---- bad stop bit then a good frame ----
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      chk("ferr.pulses", fe_cnt - fe0, 1);
      check_status("ferr");
      send_frame(8'h11, 1'b1);
      model_good(8'h11);
      check_status("after_ferr");
      pop_check("after_ferr.pop");

      // ---- overflow with five bytes into four slots ----
      for (int b = 1; b <= 5; b++) begin
         send_frame(8'(b), 1'b1);
         model_good(8'(b));
      end
      check_status("ovf");
      for (int k = 0; k < 4; k++) pop_check("ovf.pop");
      check_status("ovf.drained");
      chk("ovf.data_zero", 32'(rx_data), 0);

      // ---- push and pop on the same cycle while full ----
      do_reset();
      for (int b = 8'h21; b <= 8'h24; b++) begin
         send_frame(8'(b), 1'b1);
         model_good(8'(b));
      end
      check_status("full");
      fork
         send_frame(8'h77, 1'b1);
         begin
            @(posedge clk);
            repeat (STOP_EDGE - 1) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
         end
      join
      void'(exp_q.pop_front());
      model_good(8'h77);
      check_status("simul");
      for (int k = 0; k < 4; k++) pop_check("simul.pop");
      // pop on empty is ignored
      rd_en = 1'b1;
      @(posedge clk); #1 rd_en = 1'b0;
      check_status("empty_pop");
      chk("empty_pop.data", 32'(rx_data), 0);

      // ---- reset in the middle of data bit 4 of 0xFF ----
      send_frame(8'h42, 1'b1);
      model_good(8'h42);
      check_status("pre_rst");
      fork
         send_frame(8'hFF, 1'b1);
         begin
            @(posedge clk);
            repeat (5 * BIT + BIT / 2) @(posedge clk);
            #1 rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      model_reset();
      check_status("midrst");
      chk("midrst.data",  32'(rx_data), 0);
      chk("midrst.ferr",  32'(frame_err), 0);
      chk("midrst.state", 32'(dut.state_q), 32'(ST_IDLE));
      send_frame(8'h5A, 1'b1);
      model_good(8'h5A);
      check_status("post_rst");
      pop_check("post_rst.pop");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries (power of two, >=2).
REQ-004 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 RsRx  input  1  asynchronous UART serial line, idle high.
REQ-007 rd_en  input  1  pop request for FIFO head.
REQ-008 rx_data  output  8  FIFO head byte, first-word fall-through.
REQ-009 rx_valid  output  1  high while FIFO non-empty.
REQ-010 last_byte  output  8  most recently accepted byte, for hex display.
REQ-011 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 overflow  output  1  sticky flag, byte dropped because FIFO full.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-014 RsRx SHALL pass a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-015 Oversample tick SHALL fire once every DIV = CLK_FREQ/(BAUD*16) clocks (integer division, 651 at defaults).
REQ-016 Tick counter SHALL restart from 0 on the IDLE->START transition so sampling aligns to the start edge.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-018 IDLE: synchronized line low -> START; otherwise stay.
REQ-019 START: at 8th tick sample line; low -> DATA with tick count cleared; high -> IDLE (glitch rejected, nothing pushed).
REQ-020 DATA: sample every 16th tick, shift in LSB first; after 8th bit -> STOP.
REQ-021 STOP: at 16th tick sample line; high -> push byte, update last_byte, -> IDLE; low -> frame_err pulse, no push, -> WAIT_HIGH.
REQ-022 WAIT_HIGH: stay until synchronized line high, then -> IDLE.
REQ-023 Pushed byte SHALL appear on rx_data/rx_valid the clock after the stop-bit sample when FIFO was empty.
REQ-024 Push when full and no pop SHALL drop the byte, set overflow, leave FIFO and last_byte unchanged.
REQ-025 Push and pop in the same cycle SHALL both complete, including when full (no overflow) or empty-with-push (pop ignored, count becomes 1).
REQ-026 rd_en while empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-027 overflow SHALL clear only on rst.
REQ-028 rx_data SHALL be 0 when FIFO is empty.

Reset
REQ-029 rst SHALL force FSM to IDLE, tick and bit counters to 0, FIFO empty, fifo_count 0, rx_valid 0, rx_data 0, last_byte 0, frame_err 0, overflow 0.
REQ-030 rst mid-frame SHALL abandon the partial byte; the next complete frame SHALL be received correctly.

Structure
REQ-031 Shared package uart_pkg SHALL hold FSM state encodings, default CLK_FREQ/BAUD, and the oversample ratio 16.
REQ-032 Sub-module baud_tick_gen (counter, clear input, tick output) SHALL generate the oversample tick; FIFO stays inline.

Verification
REQ-033 Send 0xA5, 8N1 at 9600 -> rx_valid=1, rx_data=0xA5, last_byte=0xA5, fifo_count=1, frame_err never high.
REQ-034 Pulse RsRx low for 3 bit-periods/16 (under half bit) -> FSM returns IDLE, rx_valid stays 0.
REQ-035 Send 0x3C with stop bit forced low, line high afterwards -> single-cycle frame_err, fifo_count=0, last_byte unchanged; following 0x11 received normally.
REQ-036 Send 0x01..0x05 with rd_en=0 -> fifo_count=4, overflow=1, pops return 0x01,0x02,0x03,0x04 then rx_valid=0.
REQ-037 Full FIFO, assert rd_en on the cycle a new byte 0x77 is pushed -> count stays 4, overflow stays 0, 0x77 at tail.
REQ-038 Assert rst during DATA bit 4 of 0xFF -> all outputs reset values; next 0x5A received as 0x5A.
